warp_cu_arbiter: RTL and testbench
==================================

# warp_cu_arbiter

- Distributes warp allocations from the `thread_dispatcher` allocate interface across `NumCus` compute units.
- Buffers one warp in an output register and grants it round-robin to a CU that has a free warp slot and has not reached its in-flight limit.
- Tracks per-CU in-flight warps (allocated, not yet completed) and reports global idle.
- Sits between `thread_dispatcher` and the compute-unit array.

## Interface
- `NumCus`, default 4: number of compute units; must be ≥1.
- `PcWidth`, default 16: program counter width.
- `AddressWidth`, default 32: data pointer width.
- `TblockIdxBits`, default 5: thread block index width.
- `TgroupIdBits`, default 8: thread group id width.
- `MaxInflightPerCu`, default 8: per-CU in-flight warp limit; must be ≥1.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `allocate_warp_i` in 1: upstream valid.
- `warp_free_o` out 1: upstream ready.
- `allocate_pc_i` in `PcWidth`: warp PC.
- `allocate_dp_addr_i` in `AddressWidth`: data pointer.
- `allocate_tblock_idx_i` in `TblockIdxBits`: thread block index.
- `allocate_tgroup_id_i` in `TgroupIdBits`: thread group id.
- `cu_allocate_o` out `NumCus`: one-hot allocate strobe, one bit per CU.
- `cu_warp_free_i` in `NumCus`: per-CU free warp slot, a level signal.
- `cu_pc_o`, `cu_dp_addr_o`, `cu_tblock_idx_o`, `cu_tgroup_id_o` out (as inputs): payload of the held warp, broadcast to all CUs.
- `cu_warp_done_i` in `NumCus`: one-cycle pulse per completed warp.
- `idle_o` out 1: no held warp and all in-flight counters zero.
- `underflow_o` out 1: sticky error flag.

## Operation
- **Holding register**
  - State: `full` flag plus payload.
  - `warp_free_o = !full || grant_valid`.
  - On `allocate_warp_i && warp_free_o`, load the payload and set `full`.
  - On `grant_valid` without a load, clear `full`.
  - Load and grant in the same cycle: the old warp goes out, the new warp is held, and `full` stays 1.
- **Eligibility**
  - `elig[i] = cu_warp_free_i[i] && inflight[i] < MaxInflightPerCu`.
  - `grant_valid = full && |elig`.
- **Round-robin**
  - Grant goes to the first eligible index at or after `rr_ptr`, wrapping modulo `NumCus`.
  - On a grant, `rr_ptr <= (grant+1) mod NumCus`.
  - `rr_ptr` is unchanged with no grant.
  - Width is `max(1,$clog2(NumCus))`.
- **Outputs**
  - `cu_allocate_o = grant_valid ? onehot(grant) : 0`.
  - A transfer completes in the same cycle; CUs must accept any strobe while their `cu_warp_free_i` is high.
  - A CU's `cu_warp_free_i`, once high, must stay high until that CU is strobed.
- **In-flight counters**
  - One per CU, width `$clog2(MaxInflightPerCu+1)`.
  - Grant only: +1. Done only: −1. Grant and done on the same CU in one cycle: unchanged.
  - Done while the counter is 0: counter stays 0 and `underflow_o` is set; it clears only on reset.
  - A counter never exceeds `MaxInflightPerCu`, because eligibility blocks it.
- `idle_o = !full && all inflight == 0`, combinational.
- Upstream payload may change freely while `warp_free_o` is low; only the handshake cycle is sampled.

## Timing
- **Reset values:**
  - `full` = 0, `rr_ptr` = 0, all counters 0, payload registers 0, `underflow_o` = 0.
  - Therefore `cu_allocate_o` = 0, `warp_free_o` = 1, `idle_o` = 1.
- **Reset mid-operation:** a held warp is dropped. Counters clear even if warps are still running in the CUs; done pulses from those warps then raise `underflow_o`.
- **Latency:** a warp accepted at edge N is strobed to a CU at the earliest in cycle N+1 (registered; no combinational path from `allocate_*_i` to `cu_*_o`).
- **Throughput:** one warp per cycle while eligible CUs exist.
- **Combinational paths:**
  - `cu_warp_free_i` / counters → `cu_allocate_o` and `warp_free_o`.
  - `cu_warp_done_i` affects eligibility only from the next cycle (registered counter).

## Test plan
1. **Reset:** hold `rst_ni` low for 3 cycles → `cu_allocate_o` = 0, `warp_free_o` = 1, `idle_o` = 1, `underflow_o` = 0.
2. **Back-to-back round-robin:** all four CUs free, 4 warps with `tblock_idx` 0..3 on consecutive cycles → `cu_allocate_o` = 0001, 0010, 0100, 1000 in cycles N+1..N+4 with matching `tblock_idx`; counters each 1; `idle_o` = 0.
3. **Skip to free CU:** `rr_ptr` = 0, only CU2 free → CU2 granted, next `rr_ptr` = 3; the next warp with only CU0 free → CU0 granted (wrap).
4. **In-flight limit:** `NumCus`=1, `MaxInflightPerCu`=2, CU always free, 3 warps, no done → third warp is held with `warp_free_o` = 0. Done pulse at cycle M → third warp strobed in cycle M+1 and counter returns to 2.
5. **Simultaneous grant and done:** on CU1 with counter 3 → counter stays 3. A done pulse on CU3 with counter 0 → `underflow_o` = 1 and stays 1, counter stays 0.
6. **Random soak:** 1000 warps, random `cu_warp_free_i` and done timing, with a scoreboard → every warp is delivered exactly once in order, payload matches, no two strobe bits are ever set, and `idle_o` = 1 after all dones.

Source files
------------

// File: rtl/warp_cu_arbiter.sv
// Round-robin warp arbiter: holds one warp from the dispatcher and strobes it to an
// eligible compute unit, tracking per-CU in-flight warps for the idle and limit logic.
module warp_cu_arbiter #(
    parameter int NumCus           = 4,
    parameter int PcWidth          = 16,
    parameter int AddressWidth     = 32,
    parameter int TblockIdxBits    = 5,
    parameter int TgroupIdBits     = 8,
    parameter int MaxInflightPerCu = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     allocate_warp_i,
    output logic                     warp_free_o,
    input  logic [PcWidth-1:0]       allocate_pc_i,
    input  logic [AddressWidth-1:0]  allocate_dp_addr_i,
    input  logic [TblockIdxBits-1:0] allocate_tblock_idx_i,
    input  logic [TgroupIdBits-1:0]  allocate_tgroup_id_i,
    output logic [NumCus-1:0]        cu_allocate_o,
    input  logic [NumCus-1:0]        cu_warp_free_i,
    output logic [PcWidth-1:0]       cu_pc_o,
    output logic [AddressWidth-1:0]  cu_dp_addr_o,
    output logic [TblockIdxBits-1:0] cu_tblock_idx_o,
    output logic [TgroupIdBits-1:0]  cu_tgroup_id_o,
    input  logic [NumCus-1:0]        cu_warp_done_i,
    output logic                     idle_o,
    output logic                     underflow_o
);

    localparam int RrW  = (NumCus > 1) ? $clog2(NumCus) : 1;
    localparam int CntW = $clog2(MaxInflightPerCu + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxInflightPerCu);

    logic                     full_q, full_d;
    logic [PcWidth-1:0]       pc_q;
    logic [AddressWidth-1:0]  dp_addr_q;
    logic [TblockIdxBits-1:0] tblock_idx_q;
    logic [TgroupIdBits-1:0]  tgroup_id_q;
    logic [RrW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]          inflight_q [NumCus];
    logic [CntW-1:0]          inflight_d [NumCus];
    logic                     underflow_q, underflow_d;

    logic [NumCus-1:0] elig;
    logic [NumCus-1:0] cnt_zero;
    logic [RrW-1:0]    grant_idx;
    logic              grant_found;
    logic              grant_valid;
    logic              load;

    always_comb begin
        for (int i = 0; i < NumCus; i++) begin
            elig[i]     = cu_warp_free_i[i] && (inflight_q[i] < CntMax);
            cnt_zero[i] = (inflight_q[i] == '0);
        end
    end

    // Scan starting at rr_ptr; the first eligible CU wins.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NumCus; k++) begin
            if (!grant_found && elig[(int'(rr_ptr_q) + k) % NumCus]) begin
                grant_found = 1'b1;
                grant_idx   = RrW'((int'(rr_ptr_q) + k) % NumCus);
            end
        end
    end

    assign grant_valid   = full_q && grant_found;
    assign cu_allocate_o = grant_valid ? (NumCus'(1) << grant_idx) : '0;
    assign warp_free_o   = !full_q || grant_valid;
    assign load          = allocate_warp_i && warp_free_o;

    always_comb begin
        full_d      = full_q;
        rr_ptr_d    = rr_ptr_q;
        underflow_d = underflow_q;
        if (load) begin
            full_d = 1'b1;
        end else if (grant_valid) begin
            full_d = 1'b0;
        end
        if (grant_valid) begin
            rr_ptr_d = (int'(grant_idx) == NumCus - 1) ? '0 : grant_idx + 1'b1;
        end
        // A grant and a done on the same CU cancel; a lone done at zero is an error.
        for (int i = 0; i < NumCus; i++) begin
            inflight_d[i] = inflight_q[i];
            if (cu_allocate_o[i] && !cu_warp_done_i[i]) begin
                inflight_d[i] = inflight_q[i] + 1'b1;
            end else if (!cu_allocate_o[i] && cu_warp_done_i[i]) begin
                if (cnt_zero[i]) begin
                    underflow_d = 1'b1;
                end else begin
                    inflight_d[i] = inflight_q[i] - 1'b1;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q       <= 1'b0;
            pc_q         <= '0;
            dp_addr_q    <= '0;
            tblock_idx_q <= '0;
            tgroup_id_q  <= '0;
            rr_ptr_q     <= '0;
            underflow_q  <= 1'b0;
            for (int i = 0; i < NumCus; i++) begin
                inflight_q[i] <= '0;
            end
        end else begin
            full_q      <= full_d;
            rr_ptr_q    <= rr_ptr_d;
            underflow_q <= underflow_d;
            for (int i = 0; i < NumCus; i++) begin
                inflight_q[i] <= inflight_d[i];
            end
            if (load) begin
                pc_q         <= allocate_pc_i;
                dp_addr_q    <= allocate_dp_addr_i;
                tblock_idx_q <= allocate_tblock_idx_i;
                tgroup_id_q  <= allocate_tgroup_id_i;
            end
        end
    end

    assign cu_pc_o         = pc_q;
    assign cu_dp_addr_o    = dp_addr_q;
    assign cu_tblock_idx_o = tblock_idx_q;
    assign cu_tgroup_id_o  = tgroup_id_q;
    assign idle_o          = !full_q && (&cnt_zero);
    assign underflow_o     = underflow_q;

endmodule

// File: tb/tb_warp_cu_arbiter.sv
// Self-checking bench for warp_cu_arbiter: directed scenarios plus a random soak
// against a cycle-level behavioural model and an in-order delivery scoreboard.
module tb_warp_cu_arbiter;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] dp;
        logic [4:0]  tblock;
        logic [7:0]  tgroup;
    } warp_t;

    typedef struct packed {
        logic [3:0] alloc;
        logic       wf;
        logic       idle;
        logic       uf;
        warp_t      w;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Main DUT: 4 CUs, limit 8
    logic        av;
    logic        wf;
    warp_t       in_w;
    logic [3:0]  cu_alloc;
    logic [3:0]  cu_free;
    logic [3:0]  cu_done;
    warp_t       out_w;
    logic        idle;
    logic        uf;

    warp_cu_arbiter dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .allocate_warp_i       (av),
        .warp_free_o           (wf),
        .allocate_pc_i         (in_w.pc),
        .allocate_dp_addr_i    (in_w.dp),
        .allocate_tblock_idx_i (in_w.tblock),
        .allocate_tgroup_id_i  (in_w.tgroup),
        .cu_allocate_o         (cu_alloc),
        .cu_warp_free_i        (cu_free),
        .cu_pc_o               (out_w.pc),
        .cu_dp_addr_o          (out_w.dp),
        .cu_tblock_idx_o       (out_w.tblock),
        .cu_tgroup_id_o        (out_w.tgroup),
        .cu_warp_done_i        (cu_done),
        .idle_o                (idle),
        .underflow_o           (uf)
    );

    // Second DUT: 1 CU, limit 2
    logic        av1;
    logic        wf1;
    warp_t       in_w1;
    logic [0:0]  cu_alloc1;
    logic [0:0]  cu_free1;
    logic [0:0]  cu_done1;
    warp_t       out_w1;
    logic        idle1;
    logic        uf1;

    warp_cu_arbiter #(.NumCus(1), .MaxInflightPerCu(2)) dut1 (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .allocate_warp_i       (av1),
        .warp_free_o           (wf1),
        .allocate_pc_i         (in_w1.pc),
        .allocate_dp_addr_i    (in_w1.dp),
        .allocate_tblock_idx_i (in_w1.tblock),
        .allocate_tgroup_id_i  (in_w1.tgroup),
        .cu_allocate_o         (cu_alloc1),
        .cu_warp_free_i        (cu_free1),
        .cu_pc_o               (out_w1.pc),
        .cu_dp_addr_o          (out_w1.dp),
        .cu_tblock_idx_o       (out_w1.tblock),
        .cu_tgroup_id_o        (out_w1.tgroup),
        .cu_warp_done_i        (cu_done1),
        .idle_o                (idle1),
        .underflow_o           (uf1)
    );

    // Behavioural model of the 4-CU instance
    bit    m_full;
    warp_t m_w;
    int    m_rr;
    int    m_cnt [4];
    bit    m_uf;

    task automatic model_reset();
        m_full = 0;
        m_w    = '0;
        m_rr   = 0;
        m_uf   = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    function automatic bit model_busy();
        bit b;
        b = m_full;
        for (int i = 0; i < 4; i++) if (m_cnt[i] != 0) b = 1;
        return b;
    endfunction

    function automatic warp_t rand_warp();
        warp_t w;
        w.pc     = 16'($urandom);
        w.dp     = $urandom;
        w.tblock = 5'($urandom);
        w.tgroup = 8'($urandom);
        return w;
    endfunction

    function automatic warp_t mk_warp(input int tb);
        warp_t w;
        w        = rand_warp();
        w.tblock = 5'(tb);
        return w;
    endfunction

    // One clock of the main DUT: drive at negedge, sample 1 ns later, advance the model.
    task automatic step(input logic a, input warp_t p, input logic [3:0] fr,
                        input logic [3:0] dn, output obs_t o, output obs_t e);
        int g;
        bit granted;
        bit allzero;
        @(negedge clk);
        av      = a;
        in_w    = p;
        cu_free = fr;
        cu_done = dn;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_rr + k) % 4;
            if (g < 0 && fr[idx] && m_cnt[idx] < 8) g = idx;
        end
        granted = m_full && (g >= 0);
        allzero = 1;
        for (int i = 0; i < 4; i++) if (m_cnt[i] != 0) allzero = 0;
        e.alloc = '0;
        if (granted) e.alloc[g] = 1'b1;
        e.wf   = !m_full || granted;
        e.idle = !m_full && allzero;
        e.uf   = m_uf;
        e.w    = m_w;
        o.alloc = cu_alloc;
        o.wf    = wf;
        o.idle  = idle;
        o.uf    = uf;
        o.w     = out_w;
        for (int i = 0; i < 4; i++) begin
            bit gi;
            gi = granted && (g == i);
            if (gi && !dn[i]) m_cnt[i]++;
            else if (!gi && dn[i]) begin
                if (m_cnt[i] == 0) m_uf = 1;
                else m_cnt[i]--;
            end
        end
        if (granted) m_rr = (g + 1) % 4;
        if (a && e.wf) begin
            m_full = 1;
            m_w    = p;
        end else if (granted) begin
            m_full = 0;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        av       = 0; in_w  = '0; cu_free  = '0; cu_done  = '0;
        av1      = 0; in_w1 = '0; cu_free1 = '0; cu_done1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        av = 0; in_w = '0; cu_free = 4'hf; cu_done = '0;
        av1 = 0; in_w1 = '0; cu_free1 = '0; cu_done1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (cu_alloc !== 4'b0000) begin n_fail++; $display("FAIL reset_alloc: got %b want 0000", cu_alloc); end
        n_checks++;
        if (wf !== 1'b1) begin n_fail++; $display("FAIL reset_warp_free: got %b want 1", wf); end
        n_checks++;
        if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_checks++;
        if (uf !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", uf); end
        n_checks++;
        if (out_w !== '0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", out_w); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_back_to_back();
        obs_t  o, e;
        warp_t w [4];
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) w[k] = mk_warp(k);
            step(k < 4, (k < 4) ? w[k] : rand_warp(), 4'hf, 4'h0, o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_model_cycle%0d: got %h want %h", k, o, e); end
            if (k >= 1) begin
                n_checks++;
                if (o.alloc !== (4'b0001 << (k - 1)) || o.w.tblock !== 5'(k - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_strobe%0d: got %b/tb%0d want %b/tb%0d", k, o.alloc, o.w.tblock,
                             4'b0001 << (k - 1), k - 1);
                end
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dut.inflight_q[i] !== 4'd1) begin
                n_fail++; $display("FAIL b2b_count_cu%0d: got %0d want 1", i, dut.inflight_q[i]);
            end
        end
        n_checks++;
        if (idle !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", idle); end
    endtask

    task automatic test_skip_to_free();
        obs_t o, e;
        do_reset();
        step(1, mk_warp(7), 4'b0100, 4'h0, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL skip_load: got %h want %h", o, e); end
        step(0, rand_warp(), 4'b0100, 4'h0, o, e);
        n_checks++;
        if (o.alloc !== 4'b0100 || o.w.tblock !== 5'd7) begin
            n_fail++; $display("FAIL skip_cu2: got %b/tb%0d want 0100/tb7", o.alloc, o.w.tblock);
        end
        #1;
        n_checks++;
        if (dut.rr_ptr_q !== 2'd3) begin n_fail++; $display("FAIL skip_rr: got %0d want 3", dut.rr_ptr_q); end
        step(1, mk_warp(9), 4'b0001, 4'h0, o, e);
        step(0, rand_warp(), 4'b0001, 4'h0, o, e);
        n_checks++;
        if (o.alloc !== 4'b0001 || o.w.tblock !== 5'd9) begin
            n_fail++; $display("FAIL skip_wrap_cu0: got %b/tb%0d want 0001/tb9", o.alloc, o.w.tblock);
        end
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL skip_model: got %h want %h", o, e); end
    endtask

    task automatic test_inflight_limit();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            av1 = 1; in_w1 = mk_warp(k); cu_free1 = 1'b1; cu_done1 = 1'b0;
            #1;
            n_checks++;
            if (cu_alloc1 !== ((k == 0) ? 1'b0 : 1'b1) || wf1 !== 1'b1) begin
                n_fail++; $display("FAIL limit_fill%0d: got alloc %b wf %b want alloc %b wf 1", k, cu_alloc1, wf1, k != 0);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            av1 = 0; in_w1 = rand_warp();
            #1;
            n_checks++;
            if (cu_alloc1 !== 1'b0 || wf1 !== 1'b0) begin
                n_fail++; $display("FAIL limit_hold%0d: got alloc %b wf %b want 0 0", c, cu_alloc1, wf1);
            end
        end
        n_checks++;
        if (dut1.inflight_q[0] !== 2'd2) begin n_fail++; $display("FAIL limit_count: got %0d want 2", dut1.inflight_q[0]); end
        @(negedge clk);
        cu_done1 = 1'b1;
        #1;
        n_checks++;
        if (cu_alloc1 !== 1'b0) begin n_fail++; $display("FAIL limit_done_same_cycle: got %b want 0", cu_alloc1); end
        @(negedge clk);
        cu_done1 = 1'b0;
        #1;
        n_checks++;
        if (cu_alloc1 !== 1'b1 || out_w1.tblock !== 5'd2 || wf1 !== 1'b1) begin
            n_fail++; $display("FAIL limit_release: got alloc %b tb%0d wf %b want 1 tb2 1", cu_alloc1, out_w1.tblock, wf1);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dut1.inflight_q[0] !== 2'd2) begin n_fail++; $display("FAIL limit_recount: got %0d want 2", dut1.inflight_q[0]); end
    endtask

    task automatic test_grant_and_done();
        obs_t o, e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, mk_warp(k), 4'b0010, 4'h0, o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL gd_fill%0d: got %h want %h", k, o, e); end
        end
        step(0, rand_warp(), 4'b0010, 4'b0010, o, e);
        n_checks++;
        if (o.alloc !== 4'b0010 || o.w.tblock !== 5'd3) begin
            n_fail++; $display("FAIL gd_strobe: got %b/tb%0d want 0010/tb3", o.alloc, o.w.tblock);
        end
        #1;
        n_checks++;
        if (dut.inflight_q[1] !== 4'd3) begin n_fail++; $display("FAIL gd_count_cu1: got %0d want 3", dut.inflight_q[1]); end
        step(0, rand_warp(), 4'h0, 4'b1000, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL gd_underflow_pulse: got %h want %h", o, e); end
        for (int c = 0; c < 3; c++) begin
            step(0, rand_warp(), 4'h0, 4'h0, o, e);
            n_checks++;
            if (o.uf !== 1'b1) begin n_fail++; $display("FAIL gd_underflow_sticky%0d: got %b want 1", c, o.uf); end
        end
        n_checks++;
        if (dut.inflight_q[3] !== 4'd0) begin n_fail++; $display("FAIL gd_count_cu3: got %0d want 0", dut.inflight_q[3]); end
    endtask

    task automatic test_random_soak();
        obs_t       o, e;
        warp_t      sb [$];
        warp_t      p, exp_w;
        logic [3:0] fr, dn;
        logic       a;
        int         sent, delivered, cycles;
        do_reset();
        sent = 0; delivered = 0; cycles = 0; fr = '0;
        while ((delivered < 1000 || model_busy()) && cycles < 30000) begin
            a = (sent < 1000) && ($urandom_range(3) != 0);
            p = rand_warp();
            for (int i = 0; i < 4; i++) begin
                if (!fr[i]) fr[i] = ($urandom_range(2) == 0);
                dn[i] = (m_cnt[i] > 0) && ($urandom_range(3) == 0);
            end
            step(a, p, fr, dn, o, e);
            if (a && o.wf) begin
                sb.push_back(p);
                sent++;
            end
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL soak_model_cyc%0d: got %h want %h", cycles, o, e); end
            if (o.alloc !== 4'b0000) begin
                n_checks++;
                if ($countones(o.alloc) != 1) begin
                    n_fail++; $display("FAIL soak_onehot_cyc%0d: got %b want one bit", cycles, o.alloc);
                end
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL soak_spurious_cyc%0d: got strobe %b want none", cycles, o.alloc);
                end else begin
                    exp_w = sb.pop_front();
                    if (o.w !== exp_w) begin
                        n_fail++; $display("FAIL soak_payload_warp%0d: got %h want %h", delivered, o.w, exp_w);
                    end
                    delivered++;
                end
                for (int i = 0; i < 4; i++) if (o.alloc[i]) fr[i] = 1'($urandom_range(1));
            end
            cycles++;
        end
        n_checks++;
        if (cycles >= 30000) begin n_fail++; $display("FAIL soak_timeout: got %0d delivered want 1000", delivered); end
        n_checks++;
        if (delivered != 1000 || sb.size() != 0) begin
            n_fail++; $display("FAIL soak_count: got %0d delivered %0d pending want 1000 0", delivered, sb.size());
        end
        step(0, rand_warp(), 4'h0, 4'h0, o, e);
        n_checks++;
        if (o.idle !== 1'b1) begin n_fail++; $display("FAIL soak_idle: got %b want 1", o.idle); end
        n_checks++;
        if (o.uf !== 1'b0) begin n_fail++; $display("FAIL soak_underflow: got %b want 0", o.uf); end
    endtask

    initial begin
        rst_n = 1'b1;
        av = 0; in_w = '0; cu_free = '0; cu_done = '0;
        av1 = 0; in_w1 = '0; cu_free1 = '0; cu_done1 = '0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_skip_to_free();
        test_inflight_limit();
        test_grant_and_done();
        test_random_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
